// File: rtl/hamming_decode_pkg.sv
// Shared Hamming(38,32) definitions: widths, parity positions
// and the payload/syndrome helpers used by encoder and decoder.
package hamming_pkg;

  localparam int CODE_W = 38;
  localparam int DATA_W = 32;
  localparam int SYN_W  = 6;
  localparam int PAR_N  = 6;

  localparam int PAR_K [PAR_N] = '{0, 1, 3, 7, 15, 31};

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syn_t;

  localparam syn_t SYN_MAX = syn_t'(CODE_W);

  typedef struct packed {
    data_t data;
    syn_t  syn;
    logic  corr;
    logic  unc;
  } dec_t;

  function automatic logic is_parity(
    input int k
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PAR_N; i++) begin
      if (PAR_K[i] == k) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic data_t hamming_extract(
    input code_t code
  );
    data_t      d;
    logic [5:0] j;
    d = '0;
    j = '0;
    for (int k = 0; k < CODE_W; k++) begin
      if (!is_parity(k)) begin
        d[j[4:0]] = code[k];
        j = j + 6'd1;
      end
    end
    return d;
  endfunction

  function automatic syn_t hamming_syndrome(
    input code_t code
  );
    syn_t s;
    s = '0;
    for (int k = 0; k < CODE_W; k++) begin
      if (code[k]) begin
        s = s ^ syn_t'(k + 1);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_decode_if.sv
// Stream bundle for the decoder: codeword in, corrected
// payload plus status out, each with a valid/ready pair.
interface hamming_decode_if;
  import hamming_pkg::*;

  logic  in_valid;
  logic  in_ready;
  code_t in_code;

  logic  out_valid;
  logic  out_ready;
  data_t out_data;
  syn_t  out_syndrome;
  logic  out_corrected;
  logic  out_uncorrectable;

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_syndrome,
    output out_corrected,
    output out_uncorrectable
  );

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_syndrome,
    input  out_corrected,
    input  out_uncorrectable
  );

endinterface

// File: rtl/hamming_decode_err_counter.sv
// Saturating event counter with synchronous clear;
// clear beats a same-cycle increment.
module hamming_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // count up on inc, stick at all-ones, zero on clr/rst
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hamming_decode.sv
// Two-stage SEC decoder: S1 holds code+syndrome, S2 holds
// the corrected payload and flags; error counters on output.
module hamming_decode
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  hamming_decode_if.slave  bus,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  logic  s1_valid;
  code_t s1_code;
  syn_t  s1_syn;

  logic  s2_valid;
  dec_t  s2_q;

  logic  s1_adv;
  logic  s2_adv;
  logic  accept;
  logic  xfer;

  dec_t  fix;
  code_t fix_code;
  syn_t  idx;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = s1_valid && s2_adv;
  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = s2_valid && bus.out_ready;

  assign bus.in_ready = !rst && (!s1_valid || s1_adv);

  // S1: capture the codeword and its syndrome
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_code <= bus.in_code;
        s1_syn  <= hamming_syndrome(bus.in_code);
      end
    end
  end

  // classify the syndrome, flip the flagged bit, extract
  always_comb begin
    fix      = '0;
    fix_code = s1_code;
    idx      = s1_syn - syn_t'(1);
    unique case (1'b1)
      (s1_syn == '0): begin
      end
      (s1_syn != '0 && s1_syn <= SYN_MAX): begin
        fix_code[idx] = ~fix_code[idx];
        fix.corr      = 1'b1;
      end
      (s1_syn > SYN_MAX): begin
        fix.unc = 1'b1;
      end
      default: begin
      end
    endcase
    fix.syn  = s1_syn;
    fix.data = hamming_extract(fix_code);
  end

  // S2: register result; hold while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q <= fix;
      end
    end
  end

  assign bus.out_valid         = s2_valid;
  assign bus.out_data          = s2_q.data;
  assign bus.out_syndrome      = s2_q.syn;
  assign bus.out_corrected     = s2_q.corr;
  assign bus.out_uncorrectable = s2_q.unc;

  hamming_err_counter #(
    .CNT_W (CNT_W)
  ) u_corr (
    .clk   (clk),
    .rst   (rst),
    .inc   (xfer && s2_q.corr),
    .clr   (clr_counts),
    .count (corr_count)
  );

  hamming_err_counter #(
    .CNT_W (CNT_W)
  ) u_uncorr (
    .clk   (clk),
    .rst   (rst),
    .inc   (xfer && s2_q.unc),
    .clr   (clr_counts),
    .count (uncorr_count)
  );

endmodule
